ones_averager: RTL
==================

// Module: ones_averager
// PURPOSE
//   Consumes per-window results from the ones counter of the temperature-sensor
//   front end. Averages 2^LOG2_AVG consecutive window counts to cut quantisation
//   noise, and presents each average on a valid/ack handshake to the readout
//   logic. An overrun flag is raised when a new average overwrites one that was
//   never acknowledged.
// PARAMETERS
//   ONES_W    11  width of incoming ones count (= $clog2(NUMBER_OF_SAMPLES+1) upstream)
//   LOG2_AVG  3   log2 of windows per average; legal range 0..8
//   ROUND     1   1: round half-up before shift; 0: truncate (ignored when LOG2_AVG=0)
// PORTS
//   clk        in   1                  system clock, rising edge
//   rst        in   1                  synchronous, active-high reset
//   enable     in   1                  1: accept windows; 0: idle, discard partial sum
//   ones       in   ONES_W             window count from upstream, valid when ready=1
//   ready      in   1                  one-cycle strobe: ones holds a complete window
//   avg_out    out  ONES_W             averaged count, stable while avg_valid=1
//   avg_valid  out  1                  average available
//   avg_ack    in   1                  consumer accepts avg_out this cycle
//   overrun    out  1                  sticky: an unacknowledged average was overwritten
// BEHAVIOUR
//   - Reset: avg_out=0, avg_valid=0, overrun=0, acc=0, win_cnt=0, state=IDLE.
//   - Internal regs: acc[ONES_W+LOG2_AVG-1:0] (cannot overflow); win_cnt[LOG2_AVG-1:0]
//     (absent when LOG2_AVG=0).
//   - FSM IDLE: acc and win_cnt held at 0; ready is ignored. enable=1 -> ACCUM on the
//     next edge. The first ready sampled in ACCUM is a full window (upstream free-runs).
//   - FSM ACCUM: enable=0 -> IDLE next edge; acc and win_cnt cleared; partial sum lost.
//     Any ready in that same cycle is ignored.
//   - ACCUM, ready=1, win_cnt<2^LOG2_AVG-1: acc+=ones, win_cnt++.
//   - ACCUM, ready=1, win_cnt=2^LOG2_AVG-1 (final window):
//     - sum=acc+ones;
//     - avg_out<=(sum+(ROUND?2^(LOG2_AVG-1):0))>>LOG2_AVG, computed with one extra
//       bit. The result never exceeds 2^ONES_W-1, so no saturation logic is needed.
//     - avg_valid<=1; acc<=0; win_cnt<=0. Accumulation continues with no dead cycle.
//   - Latency: avg_valid and avg_out update on the edge after the final ready is sampled.
//   - Handshake: a transfer occurs on any cycle with avg_valid=1 and avg_ack=1.
//     - avg_valid clears on the next edge unless a new average loads on that edge.
//     - avg_ack while avg_valid=0 is ignored.
//   - New average loads while avg_valid=1 and avg_ack=0: avg_out is overwritten,
//     avg_valid stays 1, overrun<=1.
//   - New average loads in the same cycle as avg_ack=1: a normal transfer, avg_valid
//     stays 1, overrun is unchanged.
//   - overrun clears only on rst. enable does not affect overrun, avg_out or avg_valid;
//     a pending average survives enable=0.
//   - LOG2_AVG=0: every ready loads avg_out<=ones directly, with one-cycle latency.
//   - Reset mid-operation: all state returns to reset values on the next edge;
//     a pending average is lost.
// TESTING
//   T1 LOG2_AVG=3, ROUND=1; ones=100..107 on 8 ready strobes
//      -> avg_out=104 (832>>3), avg_valid=1 one cycle after the 8th strobe.
//   T2 same stimulus with ROUND=0 -> avg_out=103.
//   T3 ones=2047 for 8 windows, ROUND=1 -> avg_out=2047 (no wrap). Then ones=0 for
//      8 windows -> avg_out=0.
//   T4 16 windows with avg_ack held 0 -> second average overwrites the first and
//      overrun=1. Repeat with avg_ack=1 coincident with the 16th-window load
//      -> overrun=0, avg_valid stays 1.
//   T5 enable dropped after 5 windows, raised again, then 8 windows of ones=50
//      -> avg_out=50; the 5 partial windows do not contribute.
//   T6 rst asserted for 1 cycle mid-window with avg_valid=1
//      -> all outputs 0 on the next edge. LOG2_AVG=0 build: ones=77 with ready
//      -> avg_out=77 next cycle.

Source files
------------

// File: rtl/ones_averager.sv
// Averages 2^LOG2_AVG consecutive ones-counter windows and presents each result
// on a valid/ack handshake, flagging overrun when an unread average is replaced.
module ones_averager #(
    parameter int ONES_W   = 11,
    parameter int LOG2_AVG = 3,
    parameter int ROUND    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ONES_W-1:0] ones,
    input  logic              ready,
    output logic [ONES_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ack,
    output logic              overrun
);

    localparam int ACC_W  = ONES_W + LOG2_AVG;
    localparam int SUM_W  = ACC_W + 1;
    localparam int RND_SH = (LOG2_AVG > 0) ? LOG2_AVG - 1 : 0;
    localparam logic [SUM_W-1:0] RND_ADD =
        (ROUND != 0 && LOG2_AVG > 0) ? (SUM_W'(1) << RND_SH) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [ONES_W-1:0] avg_reg, avg_next;
    logic              valid_reg, valid_next;
    logic              overrun_reg, overrun_next;
    logic [SUM_W-1:0]  sum;
    logic              accum_active;
    logic              accept;
    logic              last_win;
    logic              load;

    assign accum_active = (state_reg == ACCUM) && enable;
    assign accept       = accum_active && ready;
    assign load         = accept && last_win;

    // The window counter wraps to zero on the final window by itself.
    generate
        if (LOG2_AVG > 0) begin : g_win_cnt
            logic [LOG2_AVG-1:0] win_cnt_reg, win_cnt_next;

            assign last_win = &win_cnt_reg;

            always_comb begin
                win_cnt_next = win_cnt_reg;
                if (!accum_active) begin
                    win_cnt_next = '0;
                end else if (accept) begin
                    win_cnt_next = win_cnt_reg + LOG2_AVG'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    win_cnt_reg <= '0;
                end else begin
                    win_cnt_reg <= win_cnt_next;
                end
            end
        end else begin : g_no_win_cnt
            assign last_win = 1'b1;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable)  state_next = ACCUM;
            ACCUM:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum          = {1'b0, acc_reg} + SUM_W'(ones) + RND_ADD;
        acc_next     = acc_reg;
        avg_next     = avg_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;

        if (!accum_active || load) begin
            acc_next = '0;
        end else if (accept) begin
            acc_next = acc_reg + ACC_W'(ones);
        end

        // A load coincident with an ack counts as a transfer, not an overrun.
        if (load) begin
            avg_next   = ONES_W'(sum >> LOG2_AVG);
            valid_next = 1'b1;
            if (valid_reg && !avg_ack) begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && avg_ack) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            avg_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            avg_reg     <= avg_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign avg_out   = avg_reg;
    assign avg_valid = valid_reg;
    assign overrun   = overrun_reg;

endmodule
